// File: rtl/vx_serial_mul_pkg.sv
// -----------------------------------------------------------------------------
// vx_serial_mul_pkg
//
// Purpose : Shared constants for the serial shift-add multiplier slice:
//           FSM state encodings, bits retired per step, and a helper that
//           turns the multiplier width into the number of accumulate steps.
//
// Build option:
//   VX_SERIAL_MUL_RADIX4_EN - when defined, two multiplier bits are retired
//                             per cycle (radix-4); otherwise one (radix-2).
// -----------------------------------------------------------------------------
package vx_serial_mul_pkg;

  // Two-state control FSM, kept as plain constants for legacy tools.
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

`ifdef VX_SERIAL_MUL_RADIX4_EN
  localparam int BITS_PER_STEP = 2;
`else
  localparam int BITS_PER_STEP = 1;
`endif

  // Number of accumulate/shift steps needed to consume a width_b multiplier.
  function automatic int step_count(input int width_b);
    return width_b / BITS_PER_STEP;
  endfunction

endpackage

// File: rtl/vx_serial_mul_lane.sv
// -----------------------------------------------------------------------------
// vx_serial_mul_lane
//
// Purpose : One lane of the serial multiplier. On load it captures the
//           unsigned magnitudes of both operands and the sign of the final
//           product; on each step it conditionally adds |A| into the upper
//           half of the accumulator and shifts {carry, acc, multiplier} right.
//           The low WIDTHP bits of the (optionally negated) product are
//           presented combinationally from the held registers.
//
// Ports   :
//   clk         in   clock
//   load_i      in   capture new operands (takes priority over step_i)
//   step_i      in   perform one accumulate/shift step
//   a_i         in   operand A (multiplicand), WIDTHA bits
//   b_i         in   operand B (multiplier), WIDTHB bits
//   signed_a_i  in   treat A as two's complement
//   signed_b_i  in   treat B as two's complement
//   result_o    out  low WIDTHP bits of the signed/unsigned product
//
// Build option:
//   VX_SERIAL_MUL_RADIX4_EN - retire two multiplier bits per step using a
//                             precomputed 3x|A|; otherwise one bit per step.
// -----------------------------------------------------------------------------
module vx_serial_mul_lane #(
  parameter int WIDTHA = 32,
  parameter int WIDTHB = 32,
  parameter int WIDTHP = WIDTHA + WIDTHB
) (
  input  logic              clk,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [WIDTHA-1:0] a_i,
  input  logic [WIDTHB-1:0] b_i,
  input  logic              signed_a_i,
  input  logic              signed_b_i,
  output logic [WIDTHP-1:0] result_o
);
  import vx_serial_mul_pkg::*;

  // Operand magnitudes. Negating the most-negative value wraps back to
  // 2^(W-1), which is exactly the correct unsigned magnitude.
  logic              a_neg;
  logic              b_neg;
  logic [WIDTHA-1:0] a_mag;
  logic [WIDTHB-1:0] b_mag;

  assign a_neg = signed_a_i & a_i[WIDTHA-1];
  assign b_neg = signed_b_i & b_i[WIDTHB-1];
  assign a_mag = a_neg ? -a_i : a_i;
  assign b_mag = b_neg ? -b_i : b_i;

  logic [WIDTHA-1:0] a_mag_q, a_mag_d;
  logic [WIDTHA-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTHB-1:0] mult_q, mult_d;
  logic              neg_q, neg_d;

  // Next accumulator/multiplier values for one step.
  logic [WIDTHA-1:0] acc_step;
  logic [WIDTHB-1:0] mult_step;

`ifdef VX_SERIAL_MUL_RADIX4_EN
  // 3x|A| is precomputed at load so a step never needs two adders in series.
  logic [WIDTHA+1:0] a3_q, a3_d;
  logic [WIDTHA+1:0] addend;
  logic [WIDTHA+1:0] sum;

  always_comb begin
    case (mult_q[1:0])
      2'd0:    addend = '0;
      2'd1:    addend = {2'b00, a_mag_q};
      2'd2:    addend = {1'b0, a_mag_q, 1'b0};
      default: addend = a3_q;
    endcase
  end

  // acc_hi < 2^WA and addend < 3*2^WA, so the sum fits in WA+2 bits.
  assign sum       = {2'b00, acc_hi_q} + addend;
  assign acc_step  = sum[WIDTHA+1:2];
  assign mult_step = {sum[1:0], mult_q[WIDTHB-1:2]};
`else
  logic [WIDTHA:0] sum;

  assign sum       = {1'b0, acc_hi_q} + (mult_q[0] ? {1'b0, a_mag_q} : '0);
  assign acc_step  = sum[WIDTHA:1];
  assign mult_step = {sum[0], mult_q[WIDTHB-1:1]};
`endif

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    a_mag_d  = a_mag_q;
    acc_hi_d = acc_hi_q;
    mult_d   = mult_q;
    neg_d    = neg_q;
`ifdef VX_SERIAL_MUL_RADIX4_EN
    a3_d     = a3_q;
`endif
    if (load_i) begin
      a_mag_d  = a_mag;
      acc_hi_d = '0;
      mult_d   = b_mag;
      neg_d    = a_neg ^ b_neg;
`ifdef VX_SERIAL_MUL_RADIX4_EN
      a3_d     = {2'b00, a_mag} + {1'b0, a_mag, 1'b0};
`endif
    end else if (step_i) begin
      acc_hi_d = acc_step;
      mult_d   = mult_step;
    end
  end

  // NOTE: datapath registers carry no reset; their contents are only
  // observed while the top asserts valid_out, which the control FSM gates.
  always_ff @(posedge clk) begin
    a_mag_q  <= a_mag_d;
    acc_hi_q <= acc_hi_d;
    mult_q   <= mult_d;
    neg_q    <= neg_d;
`ifdef VX_SERIAL_MUL_RADIX4_EN
    a3_q     <= a3_d;
`endif
  end

  // After the last step the multiplier register holds the low product bits.
  logic [WIDTHA+WIDTHB-1:0] prod;

  assign prod     = {acc_hi_q, mult_q};
  // A zero magnitude negates to zero, so the negate flag is harmless there.
  assign result_o = neg_q ? WIDTHP'(-prod) : WIDTHP'(prod);

endmodule

// File: rtl/vx_serial_mul.sv
// -----------------------------------------------------------------------------
// vx_serial_mul
//
// Purpose : Multi-lane serial (shift-add) multiplier with valid/ready
//           handshakes on both sides. One request is in flight at a time;
//           all lanes run in lockstep from a shared step counter and tag.
//           Latency from the accept cycle to valid_out is WIDTHB+1 cycles
//           (WIDTHB/2+1 with radix-4). The result is held until consumed.
//
// Ports   :
//   clk        in   clock
//   reset      in   synchronous, active-high reset
//   valid_in   in   request valid
//   ready_in   out  request accepted when high together with valid_in
//   dataa      in   LANES x WIDTHA operand A, lane 0 in the low bits
//   datab      in   LANES x WIDTHB operand B, lane 0 in the low bits
//   signed_a   in   treat A as two's complement
//   signed_b   in   treat B as two's complement
//   tag_in     in   request tag
//   result     out  LANES x WIDTHP low product bits, lane 0 in the low bits
//   valid_out  out  result valid
//   ready_out  in   consumer ready
//   tag_out    out  tag of the held result
//
// Build option:
//   VX_SERIAL_MUL_RADIX4_EN - two multiplier bits per cycle (WIDTHB must be
//                             even); results are bit-identical to radix-2.
// -----------------------------------------------------------------------------
module vx_serial_mul #(
  parameter int WIDTHA = 32,
  parameter int WIDTHB = 32,
  parameter int WIDTHP = WIDTHA + WIDTHB,
  parameter int LANES  = 1,
  parameter int TAGW   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic [LANES*WIDTHA-1:0] dataa,
  input  logic [LANES*WIDTHB-1:0] datab,
  input  logic                    signed_a,
  input  logic                    signed_b,
  input  logic [TAGW-1:0]         tag_in,
  output logic [LANES*WIDTHP-1:0] result,
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic [TAGW-1:0]         tag_out
);
  import vx_serial_mul_pkg::*;

  localparam int             CNT_W    = $clog2(WIDTHB + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(step_count(WIDTHB));

  logic             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TAGW-1:0]  tag_q;

  logic push;
  logic pop;
  logic step;

  // ready_in stays low for the whole BUSY period, including the pop cycle,
  // so a new request can only be accepted the cycle after a pop.
  assign ready_in  = (state_q == ST_IDLE);
  assign valid_out = (state_q == ST_BUSY) && (cnt_q == '0);
  assign push      = valid_in && ready_in;
  assign pop       = valid_out && ready_out;
  assign step      = (state_q == ST_BUSY) && (cnt_q != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (push) begin
          state_d = ST_BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      default: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
        if (pop) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // A reset mid-operation simply drops the request: the counter returns to
  // zero in IDLE so no stale valid_out can appear.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Tag is only meaningful while valid_out is high; captured with the operands.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_q <= tag_in;
    end
  end

  assign tag_out = tag_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    vx_serial_mul_lane #(
      .WIDTHA (WIDTHA),
      .WIDTHB (WIDTHB),
      .WIDTHP (WIDTHP)
    ) u_lane (
      .clk        (clk),
      .load_i     (push),
      .step_i     (step),
      .a_i        (dataa[g*WIDTHA +: WIDTHA]),
      .b_i        (datab[g*WIDTHB +: WIDTHB]),
      .signed_a_i (signed_a),
      .signed_b_i (signed_b),
      .result_o   (result[g*WIDTHP +: WIDTHP])
    );
  end

endmodule

// File: tb/tb_vx_serial_mul.sv
// -----------------------------------------------------------------------------
// tb_vx_serial_mul
//
// Self-checking bench for vx_serial_mul with WIDTHA=WIDTHB=32, WIDTHP=64,
// LANES=2, TAGW=4. Fixed vectors come from a table of hand-computed products;
// random requests are checked against a reference built from plain 64-bit
// arithmetic on sign- or zero-extended operands. Hand-written sequences cover
// back-pressure with a queued request and a reset in the middle of an
// operation. Honours VX_SERIAL_MUL_RADIX4_EN for the expected latency.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vx_serial_mul;

`ifdef VX_SERIAL_MUL_RADIX4_EN
  localparam int LAT = 32 / 2 + 1;
`else
  localparam int LAT = 32 + 1;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         valid_in;
  logic         ready_in;
  logic [63:0]  dataa;
  logic [63:0]  datab;
  logic         signed_a;
  logic         signed_b;
  logic [3:0]   tag_in;
  logic [127:0] result;
  logic         valid_out;
  logic         ready_out;
  logic [3:0]   tag_out;

  int tests = 0;
  int fails = 0;

  vx_serial_mul #(
    .WIDTHA (32),
    .WIDTHB (32),
    .WIDTHP (64),
    .LANES  (2),
    .TAGW   (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .dataa     (dataa),
    .datab     (datab),
    .signed_a  (signed_a),
    .signed_b  (signed_b),
    .tag_in    (tag_in),
    .result    (result),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .tag_out   (tag_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] a0, b0, a1, b1;
    logic        sa, sb;
    logic [63:0] e0, e1;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: extend each operand to 64 bits per its signedness; the
  // low 64 bits of the product are then correct for any sign mix.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic sa, input logic sb);
    logic [63:0] ea, eb;
    ea = sa ? 64'($signed(a)) : 64'(a);
    eb = sb ? 64'($signed(b)) : 64'(b);
    return ea * eb;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the cycle after the push; returns the cycle index (push = 0)
  // at which valid_out is first seen, or LAT+5 if it never appears.
  task automatic wait_valid(output int n);
    n = 1;
    while (valid_out !== 1'b1 && n <= LAT + 4) begin
      tick();
      n++;
    end
  endtask

  task automatic run_op(input string name,
                        input logic [31:0] a0, input logic [31:0] b0,
                        input logic [31:0] a1, input logic [31:0] b1,
                        input logic sa, input logic sb, input logic [3:0] tg,
                        input logic [63:0] e0, input logic [63:0] e1,
                        input int hold);
    int n;
    logic ok;
    check($sformatf("%s.ready_in", name), 64'(ready_in), 64'd1);
    dataa     = {a1, a0};
    datab     = {b1, b0};
    signed_a  = sa;
    signed_b  = sb;
    tag_in    = tg;
    valid_in  = 1'b1;
    ready_out = (hold == 0);
    tick();
    // Scramble the inputs so the result must come from captured operands.
    valid_in = 1'b0;
    dataa    = {$urandom, $urandom};
    datab    = {$urandom, $urandom};
    signed_a = ~sa;
    signed_b = ~sb;
    tag_in   = ~tg;
    wait_valid(n);
    check($sformatf("%s.latency", name), 64'(n), 64'(LAT));
    check($sformatf("%s.lane0", name), result[63:0], e0);
    check($sformatf("%s.lane1", name), result[127:64], e1);
    check($sformatf("%s.tag", name), 64'(tag_out), 64'(tg));
    if (hold > 0) begin
      ok = 1'b1;
      for (int h = 0; h < hold; h++) begin
        tick();
        if (result !== {e1, e0} || tag_out !== tg || valid_out !== 1'b1 || ready_in !== 1'b0)
          ok = 1'b0;
      end
      check($sformatf("%s.hold_stable", name), 64'(ok), 64'd1);
    end
    ready_out = 1'b1;
    tick();
    check($sformatf("%s.popped", name), 64'(valid_out), 64'd0);
  endtask

  initial begin
    int          n;
    logic        ok;
    logic [31:0] a0, b0, a1, b1;
    logic        sa, sb;
    logic [3:0]  tg;
    logic [63:0] f0, f1, g0, g1;

    vecs[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0,
                64'hFFFFFFFE00000001, 64'hFFFFFFFE00000001};
    vecs[1] = '{32'hFFFFFFFD, 32'h00000007, 32'h80000000, 32'h80000000, 1'b1, 1'b1,
                64'hFFFFFFFFFFFFFFEB, 64'h4000000000000000};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b0,
                64'hFFFFFFFF00000001, 64'h0000000000000000};
    vecs[3] = '{32'h00000006, 32'h00000007, 32'h00000000, 32'h00000000, 1'b0, 1'b0,
                64'h000000000000002A, 64'h0000000000000000};
    vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b1, 1'b1,
                64'h0000000000000001, 64'h0000000000000000};
    vecs[5] = '{32'h00000005, 32'hFFFFFFFF, 32'h80000000, 32'h00000002, 1'b0, 1'b1,
                64'hFFFFFFFFFFFFFFFB, 64'h0000000100000000};
    vecs[6] = '{32'h80000000, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0,
                64'h4000000000000000, 64'h00000000FFFFFFFF};
    vecs[7] = '{32'h7FFFFFFF, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1,
                64'hC000000080000000, 64'h0000000080000000};

    reset     = 1'b1;
    valid_in  = 1'b0;
    ready_out = 1'b1;
    dataa     = '0;
    datab     = '0;
    signed_a  = 1'b0;
    signed_b  = 1'b0;
    tag_in    = '0;
    tick();
    tick();
    reset = 1'b0;
    check("reset.valid_out", 64'(valid_out), 64'd0);
    check("reset.ready_in", 64'(ready_in), 64'd1);

    // Table-driven vectors, with a varying number of back-pressure cycles.
    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1,
             vecs[i].sa, vecs[i].sb, 4'(i), vecs[i].e0, vecs[i].e1, i % 3);
    end

    // Back-pressure: hold the result 10 cycles while a second request waits.
    a0 = 32'hFFFFFF9C; b0 = 32'd250; a1 = 32'h7FFFFFFF; b1 = 32'h7FFFFFFF;
    f0 = ref_mul(a0, b0, 1'b1, 1'b1);
    f1 = ref_mul(a1, b1, 1'b1, 1'b1);
    g0 = ref_mul(32'd6, 32'd7, 1'b0, 1'b0);
    g1 = ref_mul(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0);
    check("bp.ready_in", 64'(ready_in), 64'd1);
    dataa = {a1, a0}; datab = {b1, b0};
    signed_a = 1'b1; signed_b = 1'b1; tag_in = 4'hA;
    valid_in = 1'b1; ready_out = 1'b0;
    tick();
    dataa = {32'h12345678, 32'd6}; datab = {32'h9ABCDEF0, 32'd7};
    signed_a = 1'b0; signed_b = 1'b0; tag_in = 4'h5;
    wait_valid(n);
    check("bp.first.latency", 64'(n), 64'(LAT));
    check("bp.first.lane0", result[63:0], f0);
    check("bp.first.lane1", result[127:64], f1);
    check("bp.first.tag", 64'(tag_out), 64'hA);
    ok = 1'b1;
    for (int h = 0; h < 10; h++) begin
      tick();
      if (result !== {f1, f0} || tag_out !== 4'hA || valid_out !== 1'b1 || ready_in !== 1'b0)
        ok = 1'b0;
    end
    check("bp.hold_stable", 64'(ok), 64'd1);
    ready_out = 1'b1;
    check("bp.pop_cycle.ready_in", 64'(ready_in), 64'd0);
    tick();
    check("bp.after_pop.valid_out", 64'(valid_out), 64'd0);
    check("bp.after_pop.ready_in", 64'(ready_in), 64'd1);
    tick();
    valid_in = 1'b0;
    wait_valid(n);
    check("bp.second.latency", 64'(n), 64'(LAT));
    check("bp.second.lane0", result[63:0], g0);
    check("bp.second.lane1", result[127:64], g1);
    check("bp.second.tag", 64'(tag_out), 64'h5);
    tick();
    check("bp.second.popped", 64'(valid_out), 64'd0);

    // Reset in cycle 5 of an operation drops it.
    dataa = {32'd3, 32'd11}; datab = {32'd5, 32'd13};
    signed_a = 1'b0; signed_b = 1'b0; tag_in = 4'h3; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    for (int c = 1; c < 5; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst.valid_out", 64'(valid_out), 64'd0);
    check("rst.ready_in", 64'(ready_in), 64'd1);
    ok = 1'b1;
    for (int c = 0; c < LAT + 3; c++) begin
      if (valid_out !== 1'b0) ok = 1'b0;
      tick();
    end
    check("rst.no_result", 64'(ok), 64'd1);
    run_op("rst.next", 32'd6, 32'd7, 32'd0, 32'd9, 1'b0, 1'b0, 4'hC,
           64'd42, 64'd0, 0);

    // Randomized requests against the arithmetic reference.
    for (int r = 0; r < 40; r++) begin
      a0 = pick_operand(); b0 = pick_operand();
      a1 = pick_operand(); b1 = pick_operand();
      sa = 1'($urandom); sb = 1'($urandom);
      tg = 4'($urandom);
      run_op($sformatf("rand%0d", r), a0, b0, a1, b1, sa, sb, tg,
             ref_mul(a0, b0, sa, sb), ref_mul(a1, b1, sa, sb),
             $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
